fc_layer_sequencer: RTL and testbench

//  Sequences one fully-connected layer instance (fc<IN>_<OUT>, e.g. fc128_84) inside a clocked pipeline.

---
 rtl/fc_layer_sequencer.sv | 136 +++++++++++++
 tb/tb_fc_layer_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Frame sequencer around a combinational fully-connected layer: buffers an IN-element activation
// frame onto fc_x, samples fc_z after a settle delay and streams the OUT results while the next frame loads.
module fc_layer_sequencer #(
    parameter int unsigned  WIDTH  = 8,
    parameter int unsigned  IN     = 128,
    parameter int unsigned  OUT    = 84,
    parameter int unsigned  SETTLE = 2,
    localparam int unsigned ZW     = 2 * WIDTH + $clog2(IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] fc_x [IN],
    input  logic [ZW-1:0]    fc_z [OUT],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ZW-1:0]    out_data,
    output logic             out_last,
    output logic             len_err,
    output logic             busy,
    output logic [15:0]      frame_cnt
);
    localparam int unsigned ICW = (IN > 1) ? $clog2(IN) : 1;
    localparam int unsigned OCW = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int unsigned SCW = $clog2(SETTLE + 1);

    localparam logic [ICW-1:0] IN_END      = ICW'(IN - 1);
    localparam logic [OCW-1:0] OUT_END     = OCW'(OUT - 1);
    localparam logic [SCW-1:0] SETTLE_DONE = SCW'(SETTLE);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SETTLE,
        S_DRAIN,
        S_DRAIN_FULL
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [ICW-1:0] in_cnt;
    logic [ICW-1:0] in_cnt_nxt;
    logic [OCW-1:0] out_cnt;
    logic [OCW-1:0] out_cnt_nxt;
    logic [SCW-1:0] settle_cnt;
    logic [ZW-1:0]  z_buf [OUT];

    logic in_fire;
    logic in_final;
    logic in_early;
    logic out_fire;
    logic out_done;
    logic settle_done;

    assign in_fire     = in_valid && in_ready;
    assign in_final    = in_fire && (in_cnt == IN_END);
    assign in_early    = in_fire && in_last && (in_cnt != IN_END);
    assign out_fire    = out_valid && out_ready;
    assign out_done    = out_fire && out_last;
    assign settle_done = (state == S_SETTLE) && (settle_cnt == SETTLE_DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD: begin
                if (in_final) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_done) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // a frame finishing on the same edge as the last result skips straight to settling
                if (out_done)      state_nxt = in_final ? S_SETTLE : S_LOAD;
                else if (in_final) state_nxt = S_DRAIN_FULL;
            end
            S_DRAIN_FULL: begin
                if (out_done) state_nxt = S_SETTLE;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        in_cnt_nxt = in_cnt;
        if (in_fire) in_cnt_nxt = (in_final || in_last) ? '0 : in_cnt + ICW'(1);
        out_cnt_nxt = out_cnt;
        if (out_fire) out_cnt_nxt = out_last ? '0 : out_cnt + OCW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOAD;
            in_cnt     <= '0;
            out_cnt    <= '0;
            settle_cnt <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            len_err    <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
            for (int unsigned k = 0; k < IN; k++) fc_x[k] <= '0;
        end else begin
            state      <= state_nxt;
            in_cnt     <= in_cnt_nxt;
            out_cnt    <= out_cnt_nxt;
            settle_cnt <= (state == S_SETTLE && !settle_done) ? settle_cnt + SCW'(1) : '0;
            in_ready   <= (state_nxt == S_LOAD) || (state_nxt == S_DRAIN);
            len_err    <= in_early || (in_final && !in_last);
            busy       <= !((state_nxt == S_LOAD) && (in_cnt_nxt == '0));
            if (in_fire)  fc_x[in_cnt] <= in_data;
            if (out_done) frame_cnt <= frame_cnt + 16'd1;

            // first result comes straight from fc_z on the sampling edge; later ones from z_buf
            if (settle_done) begin
                out_valid <= 1'b1;
                out_data  <= fc_z[0];
                out_last  <= (OUT == 1);
            end else if (out_done) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (out_fire) begin
                out_data  <= z_buf[out_cnt_nxt];
                out_last  <= (out_cnt_nxt == OUT_END);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (settle_done) z_buf <= fc_z;
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: random frames and handshakes checked against a frame-level
// model of the result stream, handshake timing, length errors and frame count.
`timescale 1ns/1ps
module tb_fc_layer_sequencer;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned IN     = 128;
    localparam int unsigned OUT    = 84;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned ZW     = 2 * WIDTH + $clog2(IN);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic [WIDTH-1:0] fc_x [IN];
    logic [ZW-1:0]    fc_z [OUT];
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ZW-1:0]    out_data;
    logic             out_last;
    logic             len_err;
    logic             busy;
    logic [15:0]      frame_cnt;

    always #5 clk = ~clk;

    fc_layer_sequencer #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .fc_x(fc_x), .fc_z(fc_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .len_err(len_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    function automatic int unsigned wgt(input int unsigned j, input int unsigned k);
        return (j * 37 + k * 11 + 5) % 256;
    endfunction

    // stand-in for the fc layer: z[j] = sum_k x[k]*w(j,k)
    always_comb begin
        for (int j = 0; j < OUT; j++) begin
            fc_z[j] = '0;
            for (int k = 0; k < IN; k++) fc_z[j] = fc_z[j] + ZW'(fc_x[k] * wgt(j, k));
        end
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    beat_t            send_q [$];
    logic [ZW-1:0]    exp_q [$];
    logic [WIDTH-1:0] vec [IN];
    int unsigned      in_cnt_m, out_idx, pending, head_wait, cyc, last_in_edge;
    int unsigned      p_in, p_out, lerr_seen;
    logic             exp_lerr, ready_known;
    logic [15:0]      fcnt_m;
    int               total = 0;
    int               bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    // one clock: check outputs, drive inputs, advance the model for the coming edge
    task automatic cycle();
        logic  exp_ov, exp_ir, in_fire, out_fire;
        beat_t b;
        int unsigned acc;
        exp_ov = (pending > 0) && (head_wait == 0);
        exp_ir = ready_known && ((pending == 0) || (pending == 1 && head_wait == 0));
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, exp_ir);
        chk("busy", busy, (pending > 0) || (in_cnt_m != 0));
        chk("len_err", len_err, exp_lerr);
        chk("frame_cnt", frame_cnt, fcnt_m);
        if (len_err === 1'b1) lerr_seen++;
        if (exp_ov && exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0]);
            chk("out_last", out_last, out_idx == OUT - 1);
        end

        out_ready = ($urandom_range(99) < p_out);
        if (send_q.size() != 0 && $urandom_range(99) < p_in) begin
            in_valid = 1'b1;
            in_data  = send_q[0].data;
            in_last  = send_q[0].last;
        end else begin
            in_valid = 1'b0;
            in_data  = WIDTH'($urandom);
            in_last  = 1'b0;
        end
        in_fire  = in_valid && exp_ir;
        out_fire = out_ready && exp_ov;

        exp_lerr = 1'b0;
        if (head_wait > 0) head_wait--;
        if (out_fire) begin
            void'(exp_q.pop_front());
            if (out_idx == OUT - 1) begin
                out_idx = 0;
                pending--;
                fcnt_m++;
                if (pending > 0) head_wait = SETTLE + 1;
            end else begin
                out_idx++;
            end
        end
        if (in_fire) begin
            b = send_q.pop_front();
            vec[in_cnt_m] = b.data;
            if (in_cnt_m == IN - 1) begin
                for (int j = 0; j < OUT; j++) begin
                    acc = 0;
                    for (int k = 0; k < IN; k++) acc += vec[k] * wgt(j, k);
                    exp_q.push_back(ZW'(acc));
                end
                if (!b.last) exp_lerr = 1'b1;
                in_cnt_m = 0;
                pending++;
                last_in_edge = cyc + 1;
                if (pending == 1) head_wait = SETTLE + 1;
            end else if (b.last) begin
                exp_lerr = 1'b1;
                in_cnt_m = 0;
            end else begin
                in_cnt_m++;
            end
        end

        @(posedge clk);
        cyc++;
        if (rst_n) ready_known = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned n);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        send_q.delete();
        exp_q.delete();
        in_cnt_m = 0; out_idx = 0; pending = 0; head_wait = 0;
        fcnt_m = '0; exp_lerr = 1'b0; ready_known = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_fc_x_first", fc_x[0], 0);
        chk("rst_fc_x_last", fc_x[IN-1], 0);
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_frame(input int unsigned n, input bit last_ok, input bit zero);
        beat_t b;
        for (int unsigned i = 0; i < n; i++) begin
            b.data = zero ? '0 : WIDTH'($urandom);
            b.last = (i == n - 1) && last_ok;
            send_q.push_back(b);
        end
    endtask

    task automatic run_idle(input string tag, input int unsigned limit);
        int unsigned n;
        n = 0;
        while ((send_q.size() != 0 || pending != 0 || in_cnt_m != 0) && n < limit) begin
            cycle();
            n++;
        end
        if (send_q.size() != 0 || pending != 0 || in_cnt_m != 0) timeout_fail(tag);
        cycle();
    endtask

    initial begin
        int unsigned n;
        cyc = 0; last_in_edge = 0; lerr_seen = 0;
        p_in = 100; p_out = 100;

        // reset and first ready
        @(negedge clk);
        do_reset(5);
        cycle();
        chk("ready_after_reset", in_ready, 1);

        // all-zero frame, free-flowing output, settle latency
        push_frame(IN, 1, 1);
        n = 0;
        while (out_valid !== 1'b1 && n < 400) begin
            cycle();
            n++;
        end
        if (out_valid !== 1'b1) timeout_fail("zero_first_valid");
        else chk("first_valid_latency", cyc - last_in_edge, SETTLE + 1);
        run_idle("zero_frame", 400);
        chk("frame_cnt_after_zero", frame_cnt, 1);

        // random frame, then random frame under 50% output backpressure
        push_frame(IN, 1, 0);
        run_idle("random_frame", 600);
        p_in = 70; p_out = 50;
        push_frame(IN, 1, 0);
        run_idle("backpressure", 1200);

        // early in_last discards, missing in_last still processed
        p_in = 100; p_out = 100;
        lerr_seen = 0;
        push_frame(50, 1, 0);
        push_frame(IN, 1, 0);
        run_idle("early_last", 800);
        chk("early_last_pulses", lerr_seen, 1);
        lerr_seen = 0;
        push_frame(IN, 0, 0);
        run_idle("missing_last", 800);
        chk("missing_last_pulses", lerr_seen, 1);

        // overlap: B loads while A drains slowly
        do_reset(2);
        p_in = 100; p_out = 25;
        push_frame(IN, 1, 0);
        push_frame(IN, 1, 0);
        run_idle("overlap", 3000);
        chk("frame_cnt_overlap", frame_cnt, 2);

        // random mixed traffic
        p_in = 85; p_out = 60;
        for (int f = 0; f < 4; f++) push_frame(IN, 1, 0);
        run_idle("mixed", 6000);

        // reset in the middle of draining, then a clean frame
        p_in = 100; p_out = 100;
        push_frame(IN, 1, 0);
        n = 0;
        while (out_idx != 40 && n < 600) begin
            cycle();
            n++;
        end
        if (out_idx != 40) timeout_fail("mid_drain_reach");
        else chk("mid_drain_valid", out_valid, 1);
        @(negedge clk);
        do_reset(3);
        push_frame(IN, 1, 0);
        run_idle("after_reset", 600);
        chk("frame_cnt_after_reset", frame_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
